// File: rtl/bldc_commutation_sequencer_if.sv
// rtl/bldc_commutation_sequencer_if.sv - control, hall and status bundle of the BLDC commutation sequencer
interface bldc_commutation_sequencer_if #(
    parameter int REG_SIZE = 16
);
    logic                enable;
    logic                dir;
    logic                hall_1;
    logic                hall_2;
    logic                hall_3;
    logic                fault_clr;
    logic [2:0]          sector;
    logic                sector_valid;
    logic [2:0]          state;
    logic [REG_SIZE-1:0] period;
    logic                hall_error;
    logic                stall;

    modport master (
        output enable, dir, hall_1, hall_2, hall_3, fault_clr,
        input  sector, sector_valid, state, period, hall_error, stall
    );

    modport slave (
        input  enable, dir, hall_1, hall_2, hall_3, fault_clr,
        output sector, sector_valid, state, period, hall_error, stall
    );
endinterface

// File: rtl/bldc_commutation_sequencer.sv
// rtl/bldc_commutation_sequencer.sv - BLDC align/ramp/run commutation sequencer (optional glitch filter: HALL_FILTER_EN)
module bldc_commutation_sequencer #(
    parameter int REG_SIZE     = 16,
    parameter int ALIGN_CYCLES = 1000,
    parameter int RAMP_START   = 4000,
    parameter int RAMP_END     = 500,
    parameter int RAMP_STEP    = 250,
    parameter int STALL_CYCLES = 50000
) (
    input logic                        clk,
    input logic                        rst_n,
    bldc_commutation_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [REG_SIZE-1:0] ONE        = REG_SIZE'(1);
    localparam logic [REG_SIZE-1:0] ALIGN_LAST = REG_SIZE'(ALIGN_CYCLES - 1);
    localparam logic [REG_SIZE-1:0] START_W    = REG_SIZE'(RAMP_START);
    localparam logic [REG_SIZE-1:0] END_W      = REG_SIZE'(RAMP_END);
    localparam logic [REG_SIZE-1:0] STEP_W     = REG_SIZE'(RAMP_STEP);
    localparam logic [REG_SIZE-1:0] FLOOR_W    = REG_SIZE'(RAMP_END + RAMP_STEP);
    localparam logic [REG_SIZE-1:0] STALL_W    = REG_SIZE'(STALL_CYCLES);
    localparam logic [REG_SIZE-1:0] CNT_MAX    = '1;

    state_t              state_q, state_d;
    logic [2:0]          hall_s1, hall_s2, acc_code;
    logic [2:0]          sector_q, nxt_sector, acc_sector;
    logic                acc_legal, ill_prev, ramp_done;
    logic [REG_SIZE-1:0] cnt, step_period, period_q;
    logic                hall_error_q, stall_q;
    logic                run_new, run_ok, hall_fault, stall_hit, step_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1 <= 3'b000;
            hall_s2 <= 3'b000;
        end else begin
            hall_s1 <= {bus.hall_1, bus.hall_2, bus.hall_3};
            hall_s2 <= hall_s1;
        end
    end

`ifdef HALL_FILTER_EN
    logic [2:0] hist1, hist2, filt_q;

    // A code wins only once three successive synchronised samples agree; otherwise the last winner holds.
    assign acc_code = (hall_s2 == hist1 && hist1 == hist2) ? hall_s2 : filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1  <= 3'b000;
            hist2  <= 3'b000;
            filt_q <= 3'b000;
        end else begin
            hist1  <= hall_s2;
            hist2  <= hist1;
            filt_q <= acc_code;
        end
    end
`else
    assign acc_code = hall_s2;
`endif

    always_comb begin
        acc_legal  = 1'b1;
        acc_sector = 3'd0;
        case (acc_code)
            3'b101:  acc_sector = 3'd0;
            3'b100:  acc_sector = 3'd1;
            3'b110:  acc_sector = 3'd2;
            3'b010:  acc_sector = 3'd3;
            3'b011:  acc_sector = 3'd4;
            3'b001:  acc_sector = 3'd5;
            default: acc_legal  = 1'b0;
        endcase
    end

    always_comb begin
        if (bus.dir) nxt_sector = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
        else         nxt_sector = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    end

    assign run_new    = acc_legal && (acc_sector != sector_q);
    assign run_ok     = run_new && (acc_sector == nxt_sector);
    assign hall_fault = (run_new && !run_ok) || (!acc_legal && ill_prev);
    assign stall_hit  = (cnt >= STALL_W);
    assign step_hit   = (cnt == step_period - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = ALIGN;
            ALIGN:   if (!bus.enable) state_d = IDLE;
                     else if (cnt == ALIGN_LAST) state_d = RAMP;
            RAMP:    if (!bus.enable) state_d = IDLE;
                     else if (ramp_done) state_d = acc_legal ? RUN : FAULT;
            RUN:     if (!bus.enable) state_d = IDLE;
                     else if (hall_fault || stall_hit) state_d = FAULT;
            FAULT:   if (!bus.enable && bus.fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.sector_valid = (state_q == ALIGN) || (state_q == RAMP) || (state_q == RUN);
        bus.state        = state_q;
        bus.sector       = sector_q;
        bus.period       = period_q;
        bus.hall_error   = hall_error_q;
        bus.stall        = stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector_q     <= 3'd0;
            cnt          <= '0;
            step_period  <= '0;
            period_q     <= '0;
            ramp_done    <= 1'b0;
            ill_prev     <= 1'b0;
            hall_error_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            ill_prev <= !acc_legal;
            case (state_q)
                IDLE: begin
                    cnt       <= '0;
                    ramp_done <= 1'b0;
                end
                ALIGN: begin
                    sector_q <= 3'd0;
                    if (cnt == ALIGN_LAST) begin
                        cnt         <= '0;
                        step_period <= START_W;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                RAMP: if (bus.enable) begin
                    // One extra RAMP cycle after the final forced step lets that step show on the bridge.
                    if (ramp_done) begin
                        cnt <= ONE;
                        if (acc_legal) sector_q     <= acc_sector;
                        else           hall_error_q <= 1'b1;
                    end else if (step_hit) begin
                        cnt         <= '0;
                        sector_q    <= nxt_sector;
                        ramp_done   <= (step_period == END_W);
                        step_period <= (step_period >= FLOOR_W) ? step_period - STEP_W : END_W;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                RUN: if (bus.enable) begin
                    if (run_ok) begin
                        sector_q <= acc_sector;
                        period_q <= cnt;
                        cnt      <= ONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + ONE;
                    end
                    if (hall_fault) hall_error_q <= 1'b1;
                    if (stall_hit)  stall_q      <= 1'b1;
                end
                FAULT: if (!bus.enable && bus.fault_clr) begin
                    hall_error_q <= 1'b0;
                    stall_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// tb/tb_bldc_commutation_sequencer.sv - directed scoreboard bench for bldc_commutation_sequencer
module tb_bldc_commutation_sequencer;
`ifdef HALL_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bldc_commutation_sequencer_if #(.REG_SIZE(16)) bus ();

    bldc_commutation_sequencer #(
        .REG_SIZE(16), .ALIGN_CYCLES(10), .RAMP_START(40), .RAMP_END(10),
        .RAMP_STEP(10), .STALL_CYCLES(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        compare(obs);
    endtask

    task automatic set_hall(input logic [2:0] code);
        {bus.hall_1, bus.hall_2, bus.hall_3} = code;
    endtask

    // Drives a hall change and checks the sector flips exactly LAT edges later; gap spaces successive changes.
    task automatic hall_step(input logic [2:0] code, input logic [2:0] old_sec,
                             input logic [2:0] new_sec, input int gap);
        set_hall(code);
        expect_val("sector_before_latency", old_sec);
        expect_val("sector_after_latency", new_sec);
        tick(LAT - 1);
        compare(bus.sector);
        tick(1);
        compare(bus.sector);
        tick(gap - LAT);
    endtask

    task automatic go_run();
        int n = 0;
        bus.enable = 1'b1;
        while (bus.state !== 3'd3 && n < 300) begin
            tick(1);
            n++;
        end
        chk("enter_run_state", bus.state, 3);
        chk("enter_run_sector", bus.sector, 0);
    endtask

    task automatic clear_fault();
        bus.enable    = 1'b0;
        bus.fault_clr = 1'b1;
        tick(1);
        chk("clear_state", bus.state, 0);
        chk("clear_hall_error", bus.hall_error, 0);
        chk("clear_stall", bus.stall, 0);
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.dir = 1'b0;
        bus.fault_clr = 1'b0;
        set_hall(3'b111);
        tick(2);
        chk("reset_state", bus.state, 0);
        chk("reset_sector", bus.sector, 0);
        chk("reset_valid", bus.sector_valid, 0);
        chk("reset_period", bus.period, 0);
        chk("reset_hall_error", bus.hall_error, 0);
        chk("reset_stall", bus.stall, 0);

        set_hall(3'b101);
        rst_n = 1'b1;
        tick(1);
        chk("align_state", bus.state, 1);
        chk("align_valid", bus.sector_valid, 1);
        tick(9);
        chk("align_last_cycle", bus.state, 1);
        tick(1);
        chk("ramp_entry", bus.state, 2);
        tick(39);
        chk("ramp_before_step1", bus.sector, 0);
        tick(1);
        chk("ramp_step1", bus.sector, 1);
        tick(29);
        chk("ramp_before_step2", bus.sector, 1);
        tick(1);
        chk("ramp_step2", bus.sector, 2);
        tick(19);
        chk("ramp_before_step3", bus.sector, 2);
        tick(1);
        chk("ramp_step3", bus.sector, 3);
        tick(9);
        chk("ramp_before_step4", bus.sector, 3);
        tick(1);
        chk("ramp_step4", bus.sector, 4);
        chk("ramp_step4_state", bus.state, 2);
        tick(1);
        chk("run_entry_state", bus.state, 3);
        chk("run_entry_sector", bus.sector, 0);

        hall_step(3'b100, 3'd0, 3'd1, 50);
        hall_step(3'b110, 3'd1, 3'd2, 50);
        chk("run_period_50", bus.period, 50);
        hall_step(3'b010, 3'd2, 3'd3, 50);
        bus.dir = 1'b1;
        hall_step(3'b110, 3'd3, 3'd2, 50);
        hall_step(3'b100, 3'd2, 3'd1, 50);
        chk("reverse_no_error", bus.hall_error, 0);
        chk("reverse_state", bus.state, 3);
        chk("reverse_period", bus.period, 50);

        set_hall(3'b111);
        tick(1);
        set_hall(3'b100);
        tick(6);
        chk("glitch1_state", bus.state, 3);
        chk("glitch1_error", bus.hall_error, 0);

        set_hall(3'b111);
        tick(3);
        set_hall(3'b100);
        tick(8);
        chk("illegal_state", bus.state, 4);
        chk("illegal_error", bus.hall_error, 1);
        chk("illegal_valid", bus.sector_valid, 0);
        chk("illegal_sector_hold", bus.sector, 1);
        chk("illegal_no_stall", bus.stall, 0);
        bus.fault_clr = 1'b1;
        tick(2);
        chk("clr_with_enable", bus.state, 4);
        clear_fault();

        set_hall(3'b101);
        bus.dir = 1'b0;
        go_run();
        set_hall(3'b110);
        tick(LAT + 2);
        chk("jump_state", bus.state, 4);
        chk("jump_error", bus.hall_error, 1);
        chk("jump_sector_hold", bus.sector, 0);
        clear_fault();

        set_hall(3'b101);
        go_run();
        hall_step(3'b100, 3'd0, 3'd1, 50);
        set_hall(3'b110);
        tick(LAT);
        chk("stall_last_edge", bus.sector, 2);
        tick(199);
        chk("stall_not_yet", bus.state, 3);
        tick(1);
        chk("stall_state", bus.state, 4);
        chk("stall_flag", bus.stall, 1);
        chk("stall_no_hall_error", bus.hall_error, 0);
        chk("stall_period_hold", bus.period, 50);
        clear_fault();

        set_hall(3'b101);
        bus.enable = 1'b1;
        tick(30);
        chk("mid_ramp", bus.state, 2);
        bus.enable = 1'b0;
        tick(1);
        chk("disable_state", bus.state, 0);
        chk("disable_valid", bus.sector_valid, 0);
        go_run();
        hall_step(3'b100, 3'd0, 3'd1, 50);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_state", bus.state, 0);
        chk("async_reset_sector", bus.sector, 0);
        chk("async_reset_valid", bus.sector_valid, 0);
        chk("async_reset_period", bus.period, 0);
        set_hall(3'b101);
        tick(1);
        rst_n = 1'b1;

`ifdef HALL_FILTER_EN
        go_run();
        set_hall(3'b111);
        tick(2);
        set_hall(3'b101);
        tick(8);
        chk("filter_glitch_state", bus.state, 3);
        chk("filter_glitch_error", bus.hall_error, 0);
        chk("filter_glitch_sector", bus.sector, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
